hazard_ctrl_unit: RTL
=====================

# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W), replacing the single-cycle load-use detector. It generates per-stage stall/flush controls and N-operand forwarding selects. It also handles multi-cycle load-use latency, fixed-latency multi-cycle execute ops, taken-branch flushes and data-memory wait states, and keeps a saturating stall-cycle performance counter. Stage controls are combinational from the registered FSM state plus current inputs, so the pipeline registers see them in the same cycle.

## Interface
- AW, 5, register address width
- NSRC, 2, source operands per instruction (2 or 3); operand k occupies bits [k*AW +: AW]
- LOAD_LAT, 1, load-use bubbles inserted (1..7)
- MC_LAT, 4, multi-cycle execute latency in cycles (1..15)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rsD  in  NSRC*AW  decode-stage source registers
- rsE  in  NSRC*AW  execute-stage source registers (forwarding)
- rdE, rdM, rdW  in  AW  destination registers per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  destination write enables
- ResultSrcE  in  2  E-stage result source; 2'b01 = load
- McStartE  in  1  multi-cycle op present in E
- PCSrcE  in  1  taken branch/jump resolved in E
- MemReqM  in  1  load/store in M
- dmem_ready  in  1  data memory completes access this cycle
- StallF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW  out  1  stage controls
- fwd  out  NSRC*2  forwarding select per operand: 2'b00 regfile, 2'b10 from M, 2'b01 from W
- stall_cnt  out  32  cycles with StallF=1, saturating

## Operation
- Forwarding, per operand k: 2'b10 if rsE[k]==rdM && RegWriteM && rsE[k]!=0; else 2'b01 if rsE[k]==rdW && RegWriteW && rsE[k]!=0; else 2'b00. M has priority over W. 2'b11 is never produced.
- Load-use hit: ResultSrcE==2'b01 && RegWriteE && rdE!=0 && any rsD[k]==rdE.
- FSM states:
  - IDLE
  - LD_STALL: counter ld_cnt, 3 bits
  - MC_BUSY: counter mc_cnt, 4 bits
- Priority of causes, highest first: memory wait, MC_BUSY/McStart, load-use, branch.
- Memory wait (MemReqM && !dmem_ready):
  - Asserts StallF, StallD, StallE, StallM, FlushW; all other controls 0.
  - FSM state and counters hold.
- IDLE:
  - McStartE && MC_LAT>1: assert StallF, StallD, StallE, FlushM; load mc_cnt=MC_LAT-2; go to MC_BUSY.
  - Else on load-use hit: assert StallF, StallD, FlushE; if LOAD_LAT>1, load ld_cnt=LOAD_LAT-2 and go to LD_STALL.
  - Else if PCSrcE: assert FlushD, FlushE.
- MC_BUSY: assert StallF, StallD, StallE, FlushM. If mc_cnt==0 go to IDLE, else decrement. PCSrcE is ignored while E is stalled.
- LD_STALL: assert StallF, StallD, FlushE. If ld_cnt==0 go to IDLE, else decrement.
- stall_cnt: +1 on every cycle with StallF=1, including memory wait; holds at 32'hFFFF_FFFF.
- StallW is 0 always; the port is reserved.

## Timing
- rst_n low, asynchronously and regardless of other inputs:
  - state=IDLE, ld_cnt=0, mc_cnt=0, stall_cnt=0
  - every stage control and fwd driven 0
- Reset released mid-operation: restart from IDLE; any in-flight stall is abandoned.
- Stage controls and fwd are combinational; zero-cycle latency.
- Load-use inserts exactly LOAD_LAT bubbles.
- A multi-cycle op occupies E for exactly MC_LAT cycles; MC_LAT=1 behaves as a normal op.
- Memory wait extends any of the above one cycle per wait cycle, with no lost counts.
- Branch in the same cycle as load-use: the load-use stall wins. Branch in the same cycle as memory wait: no flush that cycle; the branch is re-evaluated once the wait ends.
- stall_cnt updates on the rising edge after the stalled cycle.

## Test plan
- Reset, then rsE={5'd3,5'd3}, rdM=3, RegWriteM=1, rdW=3, RegWriteW=1 -> fwd=4'b1010. Same with rsE=0 -> fwd=0.
- LOAD_LAT=2, ResultSrcE=01, rdE=7, RegWriteE=1, rsD[0]=7 for one cycle -> StallF/StallD/FlushE high for exactly 2 cycles; stall_cnt=2.
- MC_LAT=4, McStartE pulse -> StallE and FlushM high for 4 cycles; PCSrcE=1 during cycle 2 produces no FlushD.
- PCSrcE=1 in IDLE -> FlushD=FlushE=1 for that cycle only; no stall; stall_cnt unchanged.
- MC_BUSY with mc_cnt=1, then MemReqM=1, dmem_ready=0 for 3 cycles -> FlushW=1 and StallM=1 for those 3 cycles; MC_BUSY then completes normally; stall_cnt +5 in total.
- rst_n low in cycle 2 of LD_STALL -> all outputs 0 immediately; after release with no hazards, no stall.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage core: stage stall/flush controls,
// N-operand forwarding selects, multi-cycle load/execute sequencing and a stall counter.
module hazard_ctrl_unit #(
    parameter int AW       = 5,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter int MC_LAT   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*AW-1:0]   rsD,
    input  logic [NSRC*AW-1:0]   rsE,
    input  logic [AW-1:0]        rdE,
    input  logic [AW-1:0]        rdM,
    input  logic [AW-1:0]        rdW,
    input  logic                 RegWriteE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic [1:0]           ResultSrcE,
    input  logic                 McStartE,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 dmem_ready,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 StallE,
    output logic                 FlushE,
    output logic                 StallM,
    output logic                 FlushM,
    output logic                 StallW,
    output logic                 FlushW,
    output logic [NSRC*2-1:0]    fwd,
    output logic [31:0]          stall_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_STALL = 2'd1,
        MC_BUSY  = 2'd2
    } state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic flush_d;
        logic stall_e;
        logic flush_e;
        logic stall_m;
        logic flush_m;
        logic stall_w;
        logic flush_w;
    } ctrl_t;

    // Counters hold "remaining cycles after this one", so reloads are latency minus two.
    localparam logic [2:0] LD_RELOAD = 3'(LOAD_LAT - 2);
    localparam logic [3:0] MC_RELOAD = 4'(MC_LAT - 2);
    localparam logic       MC_MULTI  = (MC_LAT > 1);
    localparam logic       LD_MULTI  = (LOAD_LAT > 1);

    state_e      state_q, state_d;
    logic [2:0]  ld_cnt_q, ld_cnt_d;
    logic [3:0]  mc_cnt_q, mc_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic  mem_wait;
    logic  mc_start;
    logic  rs_match;
    logic  load_use;
    ctrl_t ctrl;

    assign mem_wait = MemReqM && !dmem_ready;
    assign mc_start = McStartE && MC_MULTI;

    always_comb begin
        rs_match = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (rsD[k*AW +: AW] == rdE) rs_match = 1'b1;
        end
    end

    assign load_use = (ResultSrcE == 2'b01) && RegWriteE && (rdE != '0) && rs_match;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ld_cnt_q    <= '0;
            mc_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        mc_cnt_d = mc_cnt_q;
        if (!mem_wait) begin
            unique case (state_q)
                IDLE: begin
                    if (mc_start) begin
                        state_d  = MC_BUSY;
                        mc_cnt_d = MC_RELOAD;
                    end else if (load_use && LD_MULTI) begin
                        state_d  = LD_STALL;
                        ld_cnt_d = LD_RELOAD;
                    end
                end
                LD_STALL: begin
                    if (ld_cnt_q == '0) state_d = IDLE;
                    else                ld_cnt_d = ld_cnt_q - 3'd1;
                end
                MC_BUSY: begin
                    if (mc_cnt_q == '0) state_d = IDLE;
                    else                mc_cnt_d = mc_cnt_q - 4'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Controls are forced low while reset is held, independent of the other inputs.
    always_comb begin
        ctrl = '0;
        if (rst_n) begin
            if (mem_wait) begin
                ctrl.stall_f = 1'b1;
                ctrl.stall_d = 1'b1;
                ctrl.stall_e = 1'b1;
                ctrl.stall_m = 1'b1;
                ctrl.flush_w = 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (mc_start) begin
                            ctrl.stall_f = 1'b1;
                            ctrl.stall_d = 1'b1;
                            ctrl.stall_e = 1'b1;
                            ctrl.flush_m = 1'b1;
                        end else if (load_use) begin
                            ctrl.stall_f = 1'b1;
                            ctrl.stall_d = 1'b1;
                            ctrl.flush_e = 1'b1;
                        end else if (PCSrcE) begin
                            ctrl.flush_d = 1'b1;
                            ctrl.flush_e = 1'b1;
                        end
                    end
                    LD_STALL: begin
                        ctrl.stall_f = 1'b1;
                        ctrl.stall_d = 1'b1;
                        ctrl.flush_e = 1'b1;
                    end
                    MC_BUSY: begin
                        ctrl.stall_f = 1'b1;
                        ctrl.stall_d = 1'b1;
                        ctrl.stall_e = 1'b1;
                        ctrl.flush_m = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctrl.stall_f && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // M-stage producer wins over W; register 0 is never forwarded.
    always_comb begin
        fwd = '0;
        if (rst_n) begin
            for (int k = 0; k < NSRC; k++) begin
                if (RegWriteM && (rsE[k*AW +: AW] == rdM) && (rsE[k*AW +: AW] != '0))
                    fwd[k*2 +: 2] = 2'b10;
                else if (RegWriteW && (rsE[k*AW +: AW] == rdW) && (rsE[k*AW +: AW] != '0))
                    fwd[k*2 +: 2] = 2'b01;
            end
        end
    end

    assign StallF    = ctrl.stall_f;
    assign StallD    = ctrl.stall_d;
    assign FlushD    = ctrl.flush_d;
    assign StallE    = ctrl.stall_e;
    assign FlushE    = ctrl.flush_e;
    assign StallM    = ctrl.stall_m;
    assign FlushM    = ctrl.flush_m;
    assign StallW    = ctrl.stall_w;
    assign FlushW    = ctrl.flush_w;
    assign stall_cnt = stall_cnt_q;

endmodule
